fu_writeback_stage: RTL and testbench
=====================================

Name: fu_writeback_stage

Overview:
- Registered writeback stage directly downstream of the function unit (ALU/shifter).
- Accepts each result `{f, v, c, n, z}` with its destination address and control bits over a valid/ready handshake, and buffers it in a small in-order FIFO.
- Drains results to the register-file write port, and updates the architectural status register (V, C, N, Z) when commanded.
- Decouples function-unit issue from register-file write-port stalls.

Parameters:
- ADDR_W, 3, destination register address width (8 registers).
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  function-unit result valid.
- IN_READY  output  1  stage can accept a result this cycle.
- IN_RES  input  20  exp_t packed `{f[15:0], v, c, n, z}`.
- IN_DA  input  ADDR_W  destination register address.
- IN_RW  input  1  write the result to the register file.
- IN_LS  input  1  load the status register from this result's flags.
- WR_READY  input  1  register-file write port accepts a write this cycle.
- WR_EN  output  1  register-file write request.
- WR_ADDR  output  ADDR_W  register-file write address.
- WR_DATA  output  16  register-file write data.
- STATUS  output  4  `{V, C, N, Z}` architectural status.
- BUSY  output  1  FIFO non-empty.
- OVF_CNT  output  16  overflow event count; present only with the optional feature.

Behaviour:
- State: storage array, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), STATUS register.
- Reset (asynchronous, any cycle):
  - count=0; pointers=0; STATUS=4'b0000.
  - WR_EN=0, IN_READY=1 (once count reads 0), BUSY=0.
  - In-flight entries are discarded; no write is issued.
  - WR_ADDR and WR_DATA reset to 0.
- IN_READY = (count != DEPTH). It depends only on registered count, not on WR_READY or IN_VALID; there is no combinational ready path.
- Push: IN_VALID & IN_READY at an edge stores `{IN_RES, IN_DA, IN_RW, IN_LS}` at tail; tail increments.
  - IN_RES, IN_DA, IN_RW and IN_LS are ignored when IN_VALID=0.
- Head outputs (combinational from the head entry, gated by count != 0):
  - WR_EN = head.rw when count != 0.
  - WR_ADDR = head.da; WR_DATA = head.f.
  - When empty, WR_ADDR and WR_DATA hold their last values (don't-care to consumers).
- Retire the head at an edge when count != 0 and either:
  - head.rw=0 — retire unconditionally, one cycle at the head; or
  - head.rw=1 and WR_READY=1.
- On retire:
  - If head.ls=1, STATUS ← `{head.v, head.c, head.n, head.z}` at the same edge.
  - head increments.
- STATUS changes only at retire edges, strictly in program order. A result with rw=0 and ls=1 (compare-style) updates only STATUS.
- Latency: a result pushed at edge k shows WR_EN=1 during cycle k+1 at the earliest, and retires at edge k+1 if WR_READY=1. Throughput is one result per cycle.
- Simultaneous push and retire in the same cycle:
  - count unchanged; both pointers advance.
  - Legal whenever IN_READY=1.
  - When full, no push occurs that cycle even if a retire happens.
- WR_READY held 0 with head.rw=1: head stalls; FIFO fills; IN_READY drops when count=DEPTH.
- Flag contents are not recomputed; the stage trusts IN_RES.
- BUSY = (count != 0).

Optional Feature:
- Macro: FU_WB_OVF_COUNT_EN.
- Defined:
  - OVF_CNT is a 16-bit counter, reset to 0.
  - It increments at every retire edge where head.v=1, regardless of ls/rw.
  - It saturates at 16'hFFFF.
- Undefined: the OVF_CNT port and counter are absent.

Decomposition:
- Package Function_Unit_pkg gains:
  - wb_entry_t `{exp_t res; logic [ADDR_W-1:0] da; logic rw; logic ls}`, using ADDR_W fixed at 3 in the package;
  - status_t `{v, c, n, z}`;
  - localparam WB_DEPTH=2.
- exp_t is reused unchanged.
- One sub-module, wb_fifo: a generic in-order FIFO of wb_entry_t with push/pop/count. The top level holds the retire logic, STATUS and the optional counter.

Test Plan:
- Reset then single push: IN_RES f=16'h1234, v=0, c=1, n=0, z=0; DA=5; RW=1; LS=1; WR_READY=1.
  - Next cycle: WR_EN=1, WR_ADDR=5, WR_DATA=16'h1234.
  - Following cycle: STATUS=4'b0100, BUSY=0.
- Backpressure: WR_READY=0 while pushing 3 results (f=1, 2, 3) on consecutive cycles.
  - IN_READY=0 once count=2; the third result is held off.
  - After WR_READY=1, writes occur in order 1, 2, 3 on three consecutive cycles.
- Compare-only entry: push RW=0, LS=1, f=16'h0000, z=1 with WR_READY=0.
  - Retires next edge; WR_EN stays 0; STATUS=4'b0001.
- Streaming: push every cycle for 8 cycles with WR_READY=1.
  - IN_READY stays 1, one write per cycle, pointer wrap correct, order preserved.
- Reset mid-operation: FIFO full and stalled, assert RESET asynchronously between edges.
  - Immediately WR_EN=0, BUSY=0, STATUS=0.
  - After release, no stale writes appear.
- With FU_WB_OVF_COUNT_EN: retire 3 results with v=1 and 1 with v=0 → OVF_CNT=3. Separately, preload near saturation → count holds at 16'hFFFF.

Source files
------------

// File: rtl/Function_Unit_pkg.sv
// rtl/Function_Unit_pkg.sv - shared function-unit result, status and writeback entry types
package Function_Unit_pkg;

    localparam int WB_ADDR_W = 3;
    localparam int WB_DEPTH  = 2;

    typedef struct packed {
        logic [15:0] f;
        logic        v;
        logic        c;
        logic        n;
        logic        z;
    } exp_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } status_t;

    typedef struct packed {
        exp_t                 res;
        logic [WB_ADDR_W-1:0] da;
        logic                 rw;
        logic                 ls;
    } wb_entry_t;

    function automatic status_t flags_of(input exp_t r);
        status_t s;
        s.v = r.v;
        s.c = r.c;
        s.n = r.n;
        s.z = r.z;
        return s;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order FIFO of writeback entries with push/pop/count
module wb_fifo
    import Function_Unit_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_entry_t                    push_data,
    input  logic                         pop,
    output wb_entry_t                    head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[head];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/fu_writeback_stage.sv
// rtl/fu_writeback_stage.sv - FU writeback buffer and status register; optional FU_WB_OVF_COUNT_EN overflow counter
module fu_writeback_stage
    import Function_Unit_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  exp_t              IN_RES,
    input  logic [ADDR_W-1:0] IN_DA,
    input  logic              IN_RW,
    input  logic              IN_LS,
    input  logic              WR_READY,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [15:0]       WR_DATA,
    output logic [3:0]        STATUS,
`ifdef FU_WB_OVF_COUNT_EN
    output logic [15:0]       OVF_CNT,
`endif
    output logic              BUSY
);

    wb_entry_t                      in_entry;
    wb_entry_t                      head;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           full;
    logic                           empty;
    logic                           push;
    logic                           retire;
    status_t                        status_q;
    logic [ADDR_W-1:0]              last_addr;
    logic [15:0]                    last_data;

    assign in_entry.res = IN_RES;
    assign in_entry.da  = IN_DA;
    assign in_entry.rw  = IN_RW;
    assign in_entry.ls  = IN_LS;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .push      (push),
        .push_data (in_entry),
        .pop       (retire),
        .head_data (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign IN_READY = ~full;
    assign BUSY     = ~empty;
    assign push     = IN_VALID & ~full;
    // Non-writing entries (compare-style) retire without waiting on the write port.
    assign retire   = ~empty & (~head.rw | WR_READY);
    assign WR_EN    = ~empty & head.rw;
    assign WR_ADDR  = empty ? last_addr : head.da;
    assign WR_DATA  = empty ? last_data : head.res.f;
    assign STATUS   = status_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            status_q  <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else if (retire) begin
            if (head.ls) status_q <= flags_of(head.res);
            last_addr <= head.da;
            last_data <= head.res.f;
        end
    end

`ifdef FU_WB_OVF_COUNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVF_CNT <= '0;
        end else if (retire && head.res.v && OVF_CNT != 16'hFFFF) begin
            OVF_CNT <= OVF_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fu_writeback_stage.sv
// tb/tb_fu_writeback_stage.sv - randomized and directed bench for fu_writeback_stage against a queue model
module tb_fu_writeback_stage;
    import Function_Unit_pkg::*;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IN_VALID;
    logic        IN_READY;
    exp_t        IN_RES;
    logic [2:0]  IN_DA;
    logic        IN_RW;
    logic        IN_LS;
    logic        WR_READY;
    logic        WR_EN;
    logic [2:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic [3:0]  STATUS;
    logic        BUSY;
`ifdef FU_WB_OVF_COUNT_EN
    logic [15:0] OVF_CNT;
`endif

    fu_writeback_stage #(.ADDR_W(3), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_RES   (IN_RES),
        .IN_DA    (IN_DA),
        .IN_RW    (IN_RW),
        .IN_LS    (IN_LS),
        .WR_READY (WR_READY),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .STATUS   (STATUS),
`ifdef FU_WB_OVF_COUNT_EN
        .OVF_CNT  (OVF_CNT),
`endif
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    wb_entry_t   q[$];
    logic [3:0]  m_status = 4'h0;
    logic [15:0] m_ovf    = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] f, input logic [3:0] vcnz);
        exp_t r;
        r.f = f;
        {r.v, r.c, r.n, r.z} = vcnz;
        return r;
    endfunction

    task automatic model_edge(input logic v, input wb_entry_t e, input logic wr);
        bit do_ret;
        bit do_push;
        do_ret  = (q.size() != 0) && (!q[0].rw || wr);
        do_push = v && (q.size() != DEPTH);
        if (do_ret) begin
            if (q[0].ls) m_status = {q[0].res.v, q[0].res.c, q[0].res.n, q[0].res.z};
            if (q[0].res.v && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(e);
    endtask

    task automatic compare();
        chk("in_ready", 32'(IN_READY), 32'(q.size() != DEPTH));
        chk("busy", 32'(BUSY), 32'(q.size() != 0));
        chk("wr_en", 32'(WR_EN), 32'((q.size() != 0) && q[0].rw));
        if (q.size() != 0) begin
            chk("wr_addr", 32'(WR_ADDR), 32'(q[0].da));
            chk("wr_data", 32'(WR_DATA), 32'(q[0].res.f));
        end
        chk("status", 32'(STATUS), 32'(m_status));
`ifdef FU_WB_OVF_COUNT_EN
        chk("ovf_cnt", 32'(OVF_CNT), 32'(m_ovf));
`endif
    endtask

    task automatic step(input logic v, input exp_t r, input logic [2:0] da,
                        input logic rw, input logic ls, input logic wr);
        wb_entry_t e;
        IN_VALID = v; IN_RES = r; IN_DA = da; IN_RW = rw; IN_LS = ls; WR_READY = wr;
        e.res = r; e.da = da; e.rw = rw; e.ls = ls;
        @(posedge CLK);
        model_edge(v, e, wr);
        @(negedge CLK);
        compare();
    endtask

    task automatic idle(input logic wr);
        step(1'b0, mk(16'h0, 4'h0), 3'd0, 1'b0, 1'b0, wr);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; IN_VALID = 0; IN_RES = '0; IN_DA = 0; IN_RW = 0; IN_LS = 0; WR_READY = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        compare();
        chk("lit_reset_wr_en", 32'(WR_EN), 32'd0);
        chk("lit_reset_in_ready", 32'(IN_READY), 32'd1);
        chk("lit_reset_wr_addr", 32'(WR_ADDR), 32'd0);
        chk("lit_reset_wr_data", 32'(WR_DATA), 32'd0);
        @(negedge CLK);

        // single push
        step(1, mk(16'h1234, 4'b0100), 3'd5, 1, 1, 1);
        chk("lit_single_wr_en", 32'(WR_EN), 32'd1);
        chk("lit_single_wr_addr", 32'(WR_ADDR), 32'd5);
        chk("lit_single_wr_data", 32'(WR_DATA), 32'h1234);
        idle(1);
        chk("lit_single_status", 32'(STATUS), 32'b0100);
        chk("lit_single_busy", 32'(BUSY), 32'd0);

        // backpressure
        step(1, mk(16'd1, 4'h0), 3'd1, 1, 0, 0);
        step(1, mk(16'd2, 4'h0), 3'd2, 1, 0, 0);
        chk("lit_bp_full_ready", 32'(IN_READY), 32'd0);
        step(1, mk(16'd3, 4'h0), 3'd3, 1, 0, 0);
        chk("lit_bp_held_busy", 32'(BUSY), 32'd1);
        chk("lit_bp_held_data", 32'(WR_DATA), 32'd1);
        step(1, mk(16'd3, 4'h0), 3'd3, 1, 0, 1);
        chk("lit_bp_second_write", 32'(WR_DATA), 32'd2);
        step(1, mk(16'd3, 4'h0), 3'd3, 1, 0, 1);
        chk("lit_bp_third_write", 32'(WR_DATA), 32'd3);
        idle(1);
        chk("lit_bp_drained", 32'(BUSY), 32'd0);

        // compare-only entry
        step(1, mk(16'h0, 4'b0001), 3'd0, 0, 1, 0);
        chk("lit_cmp_wr_en", 32'(WR_EN), 32'd0);
        idle(0);
        chk("lit_cmp_status", 32'(STATUS), 32'b0001);
        chk("lit_cmp_busy", 32'(BUSY), 32'd0);

        // streaming
        for (int i = 0; i < 8; i++) begin
            step(1, mk(16'($urandom), 4'($urandom)), 3'($urandom), 1, 1'($urandom), 1);
            chk("lit_stream_ready", 32'(IN_READY), 32'd1);
        end
        idle(1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, exp_t'(20'($urandom)), 3'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
        end
        repeat (4) idle(1);

        // reset while full and stalled
        step(1, mk(16'h0, 4'hF), 3'd0, 0, 1, 1);
        idle(1);
        step(1, mk(16'hAAAA, 4'h0), 3'd6, 1, 0, 0);
        step(1, mk(16'h5555, 4'h0), 3'd7, 1, 0, 0);
        chk("lit_pre_reset_status", 32'(STATUS), 32'hF);
        chk("lit_pre_reset_ready", 32'(IN_READY), 32'd0);
        IN_VALID = 0;
        #2 RESET = 1'b1;
        #1;
        chk("lit_async_wr_en", 32'(WR_EN), 32'd0);
        chk("lit_async_busy", 32'(BUSY), 32'd0);
        chk("lit_async_status", 32'(STATUS), 32'd0);
        q.delete();
        m_status = 4'h0;
        m_ovf = 16'h0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("lit_post_reset_wr_en", 32'(WR_EN), 32'd0);
        end

`ifdef FU_WB_OVF_COUNT_EN
        step(1, mk(16'd1, 4'b1000), 3'd1, 1, 0, 1);
        step(1, mk(16'd2, 4'b1000), 3'd2, 0, 1, 1);
        step(1, mk(16'd3, 4'b0000), 3'd3, 1, 1, 1);
        step(1, mk(16'd4, 4'b1000), 3'd4, 1, 0, 1);
        idle(1);
        chk("lit_ovf_three", 32'(OVF_CNT), 32'd3);
        for (int i = 0; i < 65540; i++) begin
            step(1, mk(16'(i), 4'b1000), 3'd0, 0, 0, 1);
        end
        idle(1);
        chk("lit_ovf_saturated", 32'(OVF_CNT), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
